clk_div_sched: RTL
==================

Name: clk_div_sched

Overview:
- Programmable, start/stop-controlled clock divider sequencer for the LTSM shared logic.
- Generates a divided clock level plus single-cycle edge strobes from i_clk.
- Accepts half-period reconfiguration via a valid/ready handshake and applies it only at a glitch-free boundary.
- With default settings it reproduces the fixed divide-by-32 used by LTSM timers, but it can be started, stopped and re-ratioed at run time.

Parameters:
- CNT_W, 8, width of the half-period counter and of the configuration value.
- DEFAULT_HALF, 16, half-period in i_clk cycles loaded at reset (full period = 2*DEFAULT_HALF = 32).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  level/pulse request to begin dividing.
- i_stop  input  1  request to stop dividing.
- i_cfg_valid  input  1  new half-period offered.
- i_cfg_half  input  CNT_W  requested half-period in i_clk cycles.
- o_cfg_ready  output  1  configuration can be accepted this cycle.
- o_cfg_err  output  1  one-cycle pulse: accepted configuration was illegal (0) and discarded.
- o_div_clk  output  1  divided clock level (registered).
- o_rise_pulse  output  1  high in the single cycle o_div_clk first reads 1.
- o_fall_pulse  output  1  high in the single cycle o_div_clk first reads 0 after being 1.
- o_busy  output  1  high in RUN and STOPPING.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset, sampled at posedge i_clk:
  - state=IDLE, cnt=0, half=DEFAULT_HALF, pending flag cleared.
  - o_div_clk=0, o_rise_pulse=0, o_fall_pulse=0, o_cfg_err=0, o_busy=0, o_cfg_ready=1.
  - Reset mid-operation drops any pending configuration and forces o_div_clk low on the next edge.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - cnt held at 0, o_div_clk=0.
  - i_start=1 and i_stop=0 -> RUN. The first toggle (0->1) occurs when cnt reaches half-1, i.e. o_div_clk reads 1 exactly half cycles after the start cycle.
  - i_start and i_stop both 1 -> stop wins; remain IDLE.
- RUN:
  - cnt increments each cycle. When cnt==half-1: cnt<=0 and o_div_clk toggles.
  - Edge strobes are registered alongside o_div_clk, so they align with the new level.
  - i_start is ignored.
  - i_stop with o_div_clk=0 -> IDLE next cycle, cnt cleared.
  - i_stop with o_div_clk=1 -> STOPPING.
- STOPPING:
  - Counting continues until the 1->0 toggle; o_fall_pulse fires; then IDLE, cnt=0.
  - No high phase is ever truncated.
  - i_start during STOPPING is ignored.
- Configuration handshake (transfer when i_cfg_valid & o_cfg_ready):
  - i_cfg_half==0: half unchanged, o_cfg_err pulses in the next cycle.
  - In IDLE: half <= i_cfg_half next cycle. A cfg in the same cycle as i_start is used from the very first phase.
  - In RUN/STOPPING: value stored as pending and o_cfg_ready drops. Pending is applied at the next 1->0 toggle, so the following low phase uses the new half. o_cfg_ready returns to 1 the cycle after application.
  - If the block enters IDLE with a pending value still outstanding, that value is applied on IDLE entry.
- Counter compare uses the current half only. Changing half never alters a phase already in progress.
- half=1 gives o_div_clk toggling every cycle (divide-by-2). Strobes then alternate every cycle.
- cnt is CNT_W bits wide. Maximum half = 2^CNT_W-1; no wrap beyond half-1.

Test Plan:
- Reset, then i_start for 1 cycle with default half=16. Required response: o_div_clk rises 16 cycles after start and has a period of 32. o_rise_pulse and o_fall_pulse are each 1 cycle wide, 16 cycles apart.
- In IDLE, set cfg half=3 together with i_start. Required response: o_div_clk period is 6, first rise 3 cycles after start, o_cfg_ready stays 1.
- RUN at half=16, send cfg half=4 during the high phase. Required response: o_cfg_ready=0 until the fall, remainder of the high phase unchanged at 16 cycles, subsequent phases 4 cycles each.
- Assert i_stop 5 cycles into a high phase at half=16. Required response: state STOPPING, fall occurs 11 cycles later, then o_busy=0 and o_div_clk stays 0. Assert i_stop in a low phase: o_busy drops the next cycle.
- cfg half=0 in IDLE. Required response: o_cfg_err pulses once, half stays 16. i_start and i_stop together in IDLE: no activity.
- Assert i_rst for 1 cycle mid-RUN with a pending cfg. Required response: all outputs at reset values next cycle, pending discarded, and a restart runs at half=16.

Source files
------------

// File: rtl/clk_div_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_sched_if
// Description : Control, configuration handshake and divided-clock outputs of
//               clk_div_sched, grouped for connection as a single port.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_sched_if #(
    parameter int CNT_W = 8
);
    logic             i_start;
    logic             i_stop;
    logic             i_cfg_valid;
    logic [CNT_W-1:0] i_cfg_half;
    logic             o_cfg_ready;
    logic             o_cfg_err;
    logic             o_div_clk;
    logic             o_rise_pulse;
    logic             o_fall_pulse;
    logic             o_busy;

    // Divider side
    modport slave (
        input  i_start, i_stop, i_cfg_valid, i_cfg_half,
        output o_cfg_ready, o_cfg_err, o_div_clk, o_rise_pulse, o_fall_pulse, o_busy
    );

    // Controller side
    modport master (
        output i_start, i_stop, i_cfg_valid, i_cfg_half,
        input  o_cfg_ready, o_cfg_err, o_div_clk, o_rise_pulse, o_fall_pulse, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_sched
// Description : Start/stop controlled clock divider with run-time half-period
//               reconfiguration applied only at the high-to-low boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_sched #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 16
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst,
    clk_div_sched_if.slave  bus
);

    localparam logic [1:0]       c_st_idle     = 2'd0;
    localparam logic [1:0]       c_st_run      = 2'd1;
    localparam logic [1:0]       c_st_stopping = 2'd2;
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic             r_pend_valid;
    logic [CNT_W-1:0] r_pend_half;
    logic             r_div_clk;
    logic             r_rise;
    logic             r_fall;
    logic             r_cfg_err;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_half_nxt;
    logic             w_pend_valid_nxt;
    logic [CNT_W-1:0] w_pend_half_nxt;
    logic             w_div_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_toggle;
    logic             w_tc;
    logic             w_xfer;
    logic             w_cfg_zero;

    assign w_tc       = (r_cnt == (r_half - c_one));
    assign w_xfer     = bus.i_cfg_valid & ~r_pend_valid;
    assign w_cfg_zero = (bus.i_cfg_half == '0);

    assign bus.o_cfg_ready  = ~r_pend_valid;
    assign bus.o_cfg_err    = r_cfg_err;
    assign bus.o_div_clk    = r_div_clk;
    assign bus.o_rise_pulse = r_rise;
    assign bus.o_fall_pulse = r_fall;
    assign bus.o_busy       = (r_state != c_st_idle);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_half       <= CNT_W'(DEFAULT_HALF);
            r_pend_valid <= 1'b0;
            r_pend_half  <= '0;
            r_div_clk    <= 1'b0;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_half       <= w_half_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_half  <= w_pend_half_nxt;
            r_div_clk    <= w_div_nxt;
            r_rise       <= w_rise_nxt;
            r_fall       <= w_fall_nxt;
            r_cfg_err    <= w_xfer & w_cfg_zero;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_div_nxt        = r_div_clk;
        w_rise_nxt       = 1'b0;
        w_fall_nxt       = 1'b0;
        w_half_nxt       = r_half;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_half_nxt  = r_pend_half;
        w_toggle         = 1'b0;

        case (r_state)
            c_st_idle: begin
                w_cnt_nxt = '0;
                w_div_nxt = 1'b0;
                if (bus.i_start && !bus.i_stop) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (bus.i_stop && !r_div_clk) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                end else begin
                    w_toggle  = w_tc;
                    w_cnt_nxt = w_tc ? '0 : r_cnt + c_one;
                    // A stop landing on the falling toggle needs no STOPPING leg
                    if (bus.i_stop) begin
                        w_state_nxt = w_tc ? c_st_idle : c_st_stopping;
                    end
                end
            end
            c_st_stopping: begin
                w_toggle  = w_tc;
                w_cnt_nxt = w_tc ? '0 : r_cnt + c_one;
                if (w_tc) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
                w_div_nxt   = 1'b0;
            end
        endcase

        if (w_toggle) begin
            w_div_nxt  = ~r_div_clk;
            w_rise_nxt = ~r_div_clk;
            w_fall_nxt = r_div_clk;
        end

        // Pending half lands only where no phase is in progress
        if (r_pend_valid && (w_fall_nxt || r_state == c_st_idle || w_state_nxt == c_st_idle)) begin
            w_half_nxt       = r_pend_half;
            w_pend_valid_nxt = 1'b0;
        end

        if (w_xfer && !w_cfg_zero) begin
            if (r_state == c_st_idle) begin
                w_half_nxt = bus.i_cfg_half;
            end else begin
                w_pend_valid_nxt = 1'b1;
                w_pend_half_nxt  = bus.i_cfg_half;
            end
        end
    end

endmodule
`default_nettype wire
